// File: rtl/rk_irq_pkg.sv
// Shared constants for the rk2040 interrupt front-end: line count, register map
// and default synchronizer depth.
package rk_irq_pkg;

  localparam int NUM_IRQ         = 8;
  localparam int IRQ_SYNC_STAGES = 2;

  localparam logic [1:0] IRQ_REG_MASK  = 2'd0;
  localparam logic [1:0] IRQ_REG_EDGE  = 2'd1;
  localparam logic [1:0] IRQ_REG_PEND  = 2'd2;
  localparam logic [1:0] IRQ_REG_FORCE = 2'd3;

endpackage

// File: rtl/irq_line_detect.sv
// One interrupt line: synchronizer, optional debounce filter (IRQ_DEBOUNCE_EN)
// and the one-cycle-delayed copy used for rising-edge detection.
module irq_line_detect #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic irqIn,
  output logic s,
  output logic rise
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : gBadParam
    $error("irq_line_detect: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   syncOut;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) syncQ <= '0;
    else     syncQ <= {syncQ[SYNC_STAGES-2:0], irqIn};
  end

  assign syncOut = syncQ[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             sDb;

  // s only follows the synchronizer after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sDb <= 1'b0;
    end else if (syncOut != sDb) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        sDb <= syncOut;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign s = sDb;
`else
  assign s = syncOut;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt source front-end: per-line detection, MASK/EDGE_SEL/PENDING/FORCE
// register file and event feed to the handler. Optional debounce: IRQ_DEBOUNCE_EN.
module irq_source_ctrl
  import rk_irq_pkg::*;
#(
  parameter int NUM_IRQ         = rk_irq_pkg::NUM_IRQ,
  parameter int SYNC_STAGES     = IRQ_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [1:0]         bus_addr,
  input  logic               bus_we,
  input  logic               bus_re,
  input  logic [NUM_IRQ-1:0] bus_wdata,
  output logic [NUM_IRQ-1:0] bus_rdata,
  output logic [NUM_IRQ-1:0] interruptSet,
  output logic [NUM_IRQ-1:0] interruptMask,
  output logic               irq_pending_any
);

  logic [NUM_IRQ-1:0] sVec;
  logic [NUM_IRQ-1:0] riseVec;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edgeSel;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] evHw;
  logic [NUM_IRQ-1:0] forceEv;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] eventAll;
  logic [NUM_IRQ-1:0] rdMux;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : gLine
    irq_line_detect #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uLine (
      .clk  (clk),
      .rst  (rst),
      .irqIn(irq_in[i]),
      .s    (sVec[i]),
      .rise (riseVec[i])
    );
  end

  // OR-ing FORCE into the hardware event collapses a coincident pair into one pulse
  assign evHw     = (edgeSel & riseVec) | (~edgeSel & sVec);
  assign forceEv  = (bus_we && bus_addr == IRQ_REG_FORCE) ? bus_wdata : '0;
  assign w1c      = (bus_we && bus_addr == IRQ_REG_PEND)  ? bus_wdata : '0;
  assign eventAll = evHw | forceEv;

  always_comb begin
    rdMux = '0;
    case (bus_addr)
      IRQ_REG_MASK: rdMux = mask;
      IRQ_REG_EDGE: rdMux = edgeSel;
      IRQ_REG_PEND: rdMux = pending;
      default:      rdMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask         <= '0;
      edgeSel      <= '0;
      pending      <= '0;
      interruptSet <= '0;
      bus_rdata    <= '0;
    end else begin
      interruptSet <= eventAll;
      pending      <= (pending & ~w1c) | eventAll;
      if (bus_we && bus_addr == IRQ_REG_MASK) mask    <= bus_wdata;
      if (bus_we && bus_addr == IRQ_REG_EDGE) edgeSel <= bus_wdata;
      if (bus_re) bus_rdata <= rdMux;
    end
  end

  assign interruptMask   = mask;
  assign irq_pending_any = |pending;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Scoreboard bench for irq_source_ctrl (default build): directed preamble then
// randomized line/bus traffic, checked cycle-by-cycle against a history-based model.
module tb_irq_source_ctrl;

  localparam int SYNC = 2;
  localparam int NCYC = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [1:0] bus_addr;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic [7:0] interruptSet;
  logic [7:0] interruptMask;
  logic       irq_pending_any;

  always #5 clk = ~clk;

  irq_source_ctrl #(
    .NUM_IRQ        (8),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_re         (bus_re),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .interruptSet   (interruptSet),
    .interruptMask  (interruptMask),
    .irq_pending_any(irq_pending_any)
  );

  typedef struct packed {
    logic [7:0] set;
    logic [7:0] mask;
    logic [7:0] rdata;
    logic       any;
  } exp_t;

  exp_t expQ[$];

  logic [7:0] irqHist[NCYC];
  bit         rstHist[NCYC];

  int errors = 0;
  int checks = 0;

  // Synchronized line value visible after edge k: the input applied SYNC-1 edges
  // earlier, unless a reset fell anywhere inside that window.
  function automatic logic [7:0] sAt(int k);
    if (k < 0) return 8'h00;
    for (int j = 0; j < SYNC; j++)
      if (k - j < 0 || rstHist[k - j]) return 8'h00;
    return irqHist[k - (SYNC - 1)];
  endfunction

  function automatic logic [7:0] prevAt(int k);
    if (k < 0 || rstHist[k]) return 8'h00;
    return sAt(k - 1);
  endfunction

  task automatic check8(string name, int cyc, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  // Stimulus and reference model
  initial begin
    logic [7:0] irqCur, mMask, mEdge, mPend, mRdata, mSet;
    logic [7:0] s1, p1, ev, frc, clr, rd;
    logic       r, we, re;
    logic [1:0] addr;
    logic [7:0] wd;
    irqCur = 8'h00; mMask = 8'h00; mEdge = 8'h00; mPend = 8'h00;
    mRdata = 8'h00; mSet = 8'h00;
    for (int c = 0; c < NCYC; c++) begin
      r = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wd = 8'h00;
      if (c < 3) begin
        r = 1'b1; irqCur = 8'h04;
      end else if (c < 60) begin
        case (c)
          6:  begin we = 1'b1; addr = 2'd1; wd = 8'hFF; end
          8:  irqCur = 8'h00;
          9:  begin we = 1'b1; addr = 2'd2; wd = 8'hFF; end
          12: irqCur = 8'h08;
          13: irqCur = 8'h00;
          18: begin re = 1'b1; addr = 2'd2; end
          20: begin we = 1'b1; addr = 2'd1; wd = 8'h00; end
          22: irqCur = 8'h20;
          32: irqCur = 8'h00;
          36: begin we = 1'b1; addr = 2'd2; wd = 8'hFF; end
          38: begin we = 1'b1; addr = 2'd1; wd = 8'hFF; end
          40: irqCur = 8'h08;
          41: irqCur = 8'h00;
          42: begin we = 1'b1; addr = 2'd2; wd = 8'h08; end
          46: begin we = 1'b1; addr = 2'd2; wd = 8'h08; end
          47: begin re = 1'b1; addr = 2'd2; end
          50: begin we = 1'b1; re = 1'b1; addr = 2'd3; wd = 8'h81; end
          52: begin we = 1'b1; re = 1'b1; addr = 2'd0; wd = 8'h5A; end
          53: begin re = 1'b1; addr = 2'd0; end
          54: begin re = 1'b1; addr = 2'd1; end
          55: begin re = 1'b1; addr = 2'd2; end
          56: begin re = 1'b1; addr = 2'd3; end
          default: ;
        endcase
      end else begin
        irqCur = irqCur ^ 8'($urandom & $urandom & $urandom);
        we   = ($urandom_range(0, 3) == 0);
        re   = ($urandom_range(0, 2) == 0);
        addr = 2'($urandom_range(0, 3));
        wd   = 8'($urandom);
        r    = ($urandom_range(0, 299) == 0);
      end

      rst = r; irq_in = irqCur; bus_we = we; bus_re = re;
      bus_addr = addr; bus_wdata = wd;
      irqHist[c] = irqCur;
      rstHist[c] = r;

      if (r) begin
        mMask = 8'h00; mEdge = 8'h00; mPend = 8'h00; mRdata = 8'h00; mSet = 8'h00;
      end else begin
        s1  = sAt(c - 1);
        p1  = prevAt(c - 1);
        ev  = (mEdge & s1 & ~p1) | (~mEdge & s1);
        frc = (we && addr == 2'd3) ? wd : 8'h00;
        clr = (we && addr == 2'd2) ? wd : 8'h00;
        rd  = (addr == 2'd0) ? mMask : (addr == 2'd1) ? mEdge :
              (addr == 2'd2) ? mPend : 8'h00;
        mSet  = ev | frc;
        mPend = (mPend & ~clr) | mSet;
        if (re) mRdata = rd;
        if (we && addr == 2'd0) mMask = wd;
        if (we && addr == 2'd1) mEdge = wd;
      end
      expQ.push_back('{set: mSet, mask: mMask, rdata: mRdata, any: |mPend});
      @(negedge clk);
    end
  end

  // Monitor: compares DUT outputs just after each active edge
  initial begin
    exp_t e;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: got no expectation required one", i);
      end else begin
        e = expQ.pop_front();
        check8("interruptSet", i, interruptSet, e.set);
        check8("interruptMask", i, interruptMask, e.mask);
        check8("bus_rdata", i, bus_rdata, e.rdata);
        check8("irq_pending_any", i, {7'd0, irq_pending_any}, {7'd0, e.any});
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_source_ctrl.md
# irq_source_ctrl

Upstream interrupt front-end for the rk2040 core. Synchronizes eight asynchronous peripheral interrupt lines and detects edges or levels on them. It holds a software-visible mask, edge-select and pending register file on the memory-mapped bus, and drives `interruptSet` and `interruptMask` straight into the interrupt handler FSM.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of interrupt lines. Fixed to 8 by the handler port width.
- `SYNC_STAGES`, 2: synchronizer flop depth per line. Minimum 2.
- `DEBOUNCE_CYCLES`, 4: stable-sample count required by the debounce filter. Used only with the macro defined.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `irq_in`, in, 8: asynchronous peripheral interrupt lines, active-high.
- `bus_addr`, in, 2: register select.
- `bus_we`, in, 1: write strobe, one cycle.
- `bus_re`, in, 1: read strobe, one cycle.
- `bus_wdata`, in, 8: write data.
- `bus_rdata`, out, 8: registered read data.
- `interruptSet`, out, 8: per-line event request to the handler.
- `interruptMask`, out, 8: current MASK register value.
- `irq_pending_any`, out, 1: OR of all PENDING bits.

## Operation
Register map:
- 0 MASK: read/write.
- 1 EDGE_SEL: read/write. 1 = rising-edge mode, 0 = level-high mode.
- 2 PENDING: read; write-1-to-clear.
- 3 FORCE: write-only, reads 0. Each 1 bit injects a software event.

Per-line path:
- `irq_in[i]` → SYNC_STAGES flops → `s[i]`. With the debounce macro defined, `s[i]` then passes through the debounce filter.
- `prev[i]` holds `s[i]` delayed by one cycle.

Event detection:
- Edge mode: `event[i] = s[i] & ~prev[i]`.
- Level mode: `event[i] = s[i]`, asserted every cycle while the line is high.
- `event_all = event | (FORCE write data when bus_we && bus_addr==3)`.

Outputs and PENDING update:
- `interruptSet <= event_all`, registered. Each edge gives a one-cycle pulse; a level line gives a continuous high.
- `interruptSet` is not gated by MASK. Masking is applied downstream using `interruptMask`.
- PENDING next value = `(PENDING & ~w1c) | event_all`. Set wins over a same-cycle W1C on the same bit.
- `irq_pending_any` is combinational from PENDING.

Bus access:
- Read: `bus_rdata` is registered from `bus_addr` when `bus_re` is high, and holds its value otherwise.
- Simultaneous `bus_we` and `bus_re`: the read returns pre-write contents.
- Writes to addresses 0 and 1 take effect on the next clock.
- A FORCE write on a bit that also has a hardware event in the same cycle produces a single pulse, not two.

## Timing
Reset values:
- All registers 0: MASK, EDGE_SEL, PENDING, synchronizer flops and `prev`.
- `interruptSet`, `bus_rdata` and `irq_pending_any` are 0.

Latency:
- `irq_in` sampled high at edge N → `interruptSet` high after edge N+SYNC_STAGES, i.e. SYNC_STAGES+1 clocks (3 at default).
- PENDING sets on the same edge as `interruptSet`.
- FORCE write at edge N → `interruptSet` pulse and PENDING set after edge N.
- Read data is valid the cycle after `bus_re`.

Boundary conditions:
- A line held high through reset release counts as a rising edge once it reaches `s`. This yields exactly one event in edge mode.
- Changing EDGE_SEL while a line is high:
  - To edge mode: no event until the next rising edge.
  - To level mode: events begin the next cycle.
- Reset asserted mid-operation clears all state on that edge. Any in-flight pulse is dropped.

## Configuration
- `IRQ_DEBOUNCE_EN` defined:
  - A per-line counter of width `$clog2(DEBOUNCE_CYCLES+1)` sits between the synchronizer and `s`.
  - `s[i]` takes the synchronized value only after that value has differed from `s[i]` for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch gap resets the count.
  - Adds DEBOUNCE_CYCLES clocks of latency. Glitches shorter than that are rejected.
- `IRQ_DEBOUNCE_EN` undefined: no counters; the synchronizer output drives `s` directly.

## Structure
- Package `rk_irq_pkg` holds:
  - `NUM_IRQ`.
  - Register address constants `IRQ_REG_MASK`, `IRQ_REG_EDGE`, `IRQ_REG_PEND`, `IRQ_REG_FORCE`.
  - Default `SYNC_STAGES`.
- Sub-module `irq_line_detect`, instantiated NUM_IRQ times. It contains the synchronizer, the optional debounce filter and the `prev` flop, and outputs `s` and `rise`.
- Top level holds the register file, event combine and bus read mux.

## Test plan
- Reset, then read all four addresses → 0x00 each; `interruptSet` = 0x00.
- EDGE_SEL=0xFF, pulse `irq_in[3]` high for 1 cycle → `interruptSet` = 0x08 for exactly one cycle, 3 clocks later. PENDING reads 0x08.
- EDGE_SEL=0x00, hold `irq_in[5]` high 10 cycles → `interruptSet[5]` high for 10 cycles, delayed by 3 clocks.
- PENDING=0x08, write 0x08 to address 2 in the same cycle as a new event on line 3 → PENDING stays 0x08. Write 0x08 again with no event → PENDING reads 0x00.
- Write 0x81 to FORCE → `interruptSet` = 0x81 for one cycle after the write edge. `irq_pending_any` = 1.
- With `IRQ_DEBOUNCE_EN`, DEBOUNCE_CYCLES=4: a 3-cycle glitch on `irq_in[0]` → no event. A 6-cycle high → one event at 3+4 clocks.
